// File: rtl/axil_bram_responder.sv
// -----------------------------------------------------------------------------
// axil_bram_responder
//
// AXI4-Lite slave backed by a word-addressed on-chip RAM (MEM_DEPTH x 32b).
// It holds register and weight storage for the Ising sampler. Only single-beat
// transactions are accepted, with one write and one read outstanding at a time.
//
// Build option:
//   AXIL_BRAM_USR_PORT_EN - adds a second, independent RAM read port
//                           (usr_en / usr_addr / usr_rdata) for sampler logic.
//
// Ports:
//   ACLK, ARESETN          clock (rising edge), asynchronous active-low reset
//   S_AXI_AW*              write address channel (addr bits [1:0] ignored)
//   S_AXI_W*               write data channel with byte strobes
//   S_AXI_B*               write response (OKAY / SLVERR)
//   S_AXI_AR*              read address channel (addr bits [1:0] ignored)
//   S_AXI_R*               read data channel (OKAY / SLVERR, RDATA=0 on error)
//   usr_en, usr_addr       user read request (option only)
//   usr_rdata              user read data, valid one cycle after usr_en
// -----------------------------------------------------------------------------
`default_nettype none

module axil_bram_responder #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int MEM_DEPTH          = 256
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
`ifdef AXIL_BRAM_USR_PORT_EN
    input  logic                              usr_en,
    input  logic [$clog2(MEM_DEPTH)-1:0]      usr_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     usr_rdata,
`endif
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY
);

    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int SW    = DW / 8;
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int WA_W  = C_S_AXI_ADDR_WIDTH - 2;   // word address width

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] W_IDLE   = 2'd0;
    localparam logic [1:0] W_COMMIT = 2'd1;
    localparam logic [1:0] W_RESP   = 2'd2;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_ISSUE = 2'd1;
    localparam logic [1:0] R_RESP  = 2'd2;

    // Any word-address bit above the RAM index makes the access out of range.
    function automatic logic out_of_range(input logic [WA_W-1:0] wa);
        return (wa >> IDX_W) != '0;
    endfunction

    logic [DW-1:0] mem [MEM_DEPTH];

    logic [1:0]      w_state;
    logic [1:0]      r_state;
    logic            aw_held, w_held;
    logic            awready_r, wready_r, arready_r;
    logic            bvalid_r, rvalid_r;
    logic [1:0]      bresp_r, rresp_r;
    logic [DW-1:0]   rdata_r;

    logic [WA_W-1:0] awaddr_q;
    logic [WA_W-1:0] araddr_q;
    logic [DW-1:0]   wdata_q;
    logic [SW-1:0]   wstrb_q;

    logic aw_hs, w_hs, ar_hs;
    assign aw_hs = S_AXI_AWVALID && awready_r;
    assign w_hs  = S_AXI_WVALID  && wready_r;
    assign ar_hs = S_AXI_ARVALID && arready_r;

    // Protection bits and byte offsets carry no meaning for this RAM.
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Payload capture: data registers only, no reset needed.
    always_ff @(posedge ACLK) begin
        if (aw_hs) awaddr_q <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
        if (w_hs) begin
            wdata_q <= S_AXI_WDATA;
            wstrb_q <= S_AXI_WSTRB;
        end
        if (ar_hs) araddr_q <= S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    end

    // RAM write port. Gated by W_COMMIT, which the async reset clears, so a
    // reset mid-transaction can never produce a partial write.
    always_ff @(posedge ACLK) begin
        if (w_state == W_COMMIT && !out_of_range(awaddr_q)) begin
            for (int b = 0; b < SW; b++) begin
                if (wstrb_q[b]) mem[awaddr_q[IDX_W-1:0]][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    // Write FSM: AW and W are held independently until both are present.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state   <= W_IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) aw_held <= 1'b1;
                    if (w_hs)  w_held  <= 1'b1;
                    awready_r <= !(aw_held || aw_hs);
                    wready_r  <= !(w_held || w_hs);
                    if ((aw_held || aw_hs) && (w_held || w_hs)) w_state <= W_COMMIT;
                end
                W_COMMIT: begin
                    aw_held  <= 1'b0;
                    w_held   <= 1'b0;
                    bvalid_r <= 1'b1;
                    bresp_r  <= out_of_range(awaddr_q) ? RESP_SLVERR : RESP_OKAY;
                    w_state  <= W_RESP;
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_r  <= 1'b0;
                        awready_r <= 1'b1;
                        wready_r  <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read FSM. A read issued while a write commits waits one cycle so it
    // returns the freshly written data.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state   <= R_IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rresp_r   <= RESP_OKAY;
            rdata_r   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    arready_r <= !ar_hs;
                    if (ar_hs) r_state <= R_ISSUE;
                end
                R_ISSUE: begin
                    if (w_state != W_COMMIT) begin
                        rvalid_r <= 1'b1;
                        if (out_of_range(araddr_q)) begin
                            rdata_r <= '0;
                            rresp_r <= RESP_SLVERR;
                        end else begin
                            rdata_r <= mem[araddr_q[IDX_W-1:0]];
                            rresp_r <= RESP_OKAY;
                        end
                        r_state <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (S_AXI_RREADY) begin
                        rvalid_r  <= 1'b0;
                        arready_r <= 1'b1;
                        r_state   <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

`ifdef AXIL_BRAM_USR_PORT_EN
    // Second read port; a same-cycle write to the same word returns old data.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            usr_rdata <= '0;
        end else if (usr_en) begin
            usr_rdata <= mem[usr_addr];
        end
    end
`endif

    assign S_AXI_AWREADY = awready_r;
    assign S_AXI_WREADY  = wready_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = bresp_r;
    assign S_AXI_ARREADY = arready_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RRESP   = rresp_r;
    assign S_AXI_RDATA   = rdata_r;

endmodule

`default_nettype wire
